// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings and constants for the instruction fetch unit
// Contents:
//   ST_IDLE/ST_WAIT/ST_DROP  fetch FSM state encoding
//   INST_BYTES               PC increment per instruction
//   ENTRY_W                  FIFO entry width: {pc[63:32], instr[31:0]}
//   align_pc()               force a fetch address to a word boundary
package fetch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam int INST_BYTES = 4;
  localparam int ENTRY_W    = 64;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - show-ahead synchronous FIFO buffering fetched instructions
// Ports:
//   clk, rst     clock, synchronous active-low reset (clears storage too)
//   flush        drop all entries; overrides same-cycle push/pop
//   push, wdata  write one entry
//   pop          remove head entry (ignored when empty)
//   head         current head entry, valid whenever count != 0
//   count        occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   FULL    = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        // The fetch FSM only requests when a slot is guaranteed free.
        assert (count != FULL);
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage feeding the core decode stage
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   mem_req, mem_addr              registered read request to instruction memory
//   mem_ack, mem_rdata             one-cycle completion pulse with instruction word
//   inst_valid, inst, inst_pc      head of the instruction buffer
//   inst_ready                     core takes the head this cycle
//   redirect, redirect_pc          flush and restart fetch at a new address
//   fifo_count                     buffer occupancy
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   STEP = 32'(INST_BYTES);

  logic [1:0]         state;
  logic [31:0]        fetch_pc;
  logic               pop;
  logic               push;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      cnt_after_pop;
  logic [CW-1:0]      cnt_after_all;

  // Redirect kills both sides of the buffer in the cycle it arrives.
  assign pop        = inst_valid && inst_ready && !redirect;
  assign push       = (state == ST_WAIT) && mem_ack && !redirect;
  assign inst_valid = (fifo_count != '0);
  assign inst       = head[31:0];
  assign inst_pc    = head[63:32];

  // Occupancy as it will be after this edge; decides whether another
  // request may be launched without risking overflow.
  assign cnt_after_pop = fifo_count - CW'(pop);
  assign cnt_after_all = cnt_after_pop + CW'(push);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata ({fetch_pc, mem_rdata}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
      case (state)
        // An un-acked request is on the wrong path; wait it out in DROP.
        ST_WAIT, ST_DROP: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end else begin
            state <= ST_DROP;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (cnt_after_pop < FULL) begin
            state    <= ST_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + STEP;
            if (cnt_after_all < FULL) begin
              mem_addr <= fetch_pc + STEP;
            end else begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic [31:0]            mem_rdata;
  logic                   inst_valid;
  logic [31:0]            inst;
  logic [31:0]            inst_pc;
  logic                   inst_ready = 1'b0;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = 32'h0;
  logic [$clog2(DEPTH):0] fifo_count;

  int          checks = 0;
  int          errors = 0;
  logic        auto_mem = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] key = 32'h0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  inst_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Memory model: word at address A is A ^ key; latency drawn per request.
  initial begin
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!auto_mem) begin
        mem_ack = man_ack;
        mem_rdata = man_rdata;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
        cnt++;
        if (cnt >= cur_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr ^ key;
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic reset_dut();
    rst = 1'b0;
    redirect = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    auto_mem = 1'b1; lat_min = 1; lat_max = 1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int pops;
    exp = 32'h0; pops = 0;
    key = 32'h0; lat_min = 1; lat_max = 1; auto_mem = 1'b1;
    reset_dut();
    inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (inst_valid !== 1'b1 || mem_req !== 1'b1) begin
          errors++; $display("FAIL stream_steady: got valid=%b req=%b expected 1 1", inst_valid, mem_req);
        end
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== exp || inst !== exp) begin
          errors++; $display("FAIL stream_inst: got pc=%h inst=%h expected %h", inst_pc, inst, exp);
        end
        exp += 32'd4; pops++;
      end
    end
    checks++; if (pops != 15) begin errors++; $display("FAIL stream_pops: got %0d expected 15", pops); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    logic req_seen;
    exp = 32'h0; req_seen = 1'b0;
    key = $urandom; lat_min = 1; lat_max = 1; auto_mem = 1'b1;
    reset_dut();
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full_count: got %0d expected 4", fifo_count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_off: got %b expected 0", mem_req); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", inst_pc); end
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      inst_ready = 1'b1;
      if (!req_seen && mem_req) begin
        req_seen = 1'b1;
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_addr: got %h expected 10", mem_addr); end
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== exp || inst !== (exp ^ key)) begin
          errors++; $display("FAIL bp_inst: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp, exp ^ key);
        end
        exp += 32'd4;
      end
    end
    checks++; if (!req_seen || exp < 32'h14) begin errors++; $display("FAIL bp_progress: got next pc %h expected at least 14", exp); end
  endtask

  task automatic test_redirect_drop();
    int phase;
    int k;
    logic done;
    phase = 0; k = 0; done = 1'b0;
    key = $urandom; lat_min = 5; lat_max = 5; auto_mem = 1'b1;
    reset_dut();
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      case (phase)
        0: begin
          if (mem_req) begin
            k++;
            checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL drop_addr_hold: got %h expected 0", mem_addr); end
            if (k == 2) begin redirect = 1'b1; redirect_pc = 32'h100; end
          end else if (k > 0) begin
            checks++; if (k != 5) begin errors++; $display("FAIL drop_req_cycles: got %0d expected 5", k); end
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_discard: got valid=%b expected 0", inst_valid); end
            phase = 1;
          end
        end
        1: begin
          if (mem_req) begin
            checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL drop_new_addr: got %h expected 100", mem_addr); end
            phase = 2;
          end
        end
        default: begin
          if (inst_valid) begin
            checks++;
            if (inst_pc !== 32'h100 || inst !== (32'h100 ^ key)) begin
              errors++; $display("FAIL drop_first_inst: got pc=%h inst=%h expected pc=100 inst=%h", inst_pc, inst, 32'h100 ^ key);
            end
            done = 1'b1;
          end
        end
      endcase
    end
    redirect = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL drop_timeout: got phase %0d expected completion", phase); end
  endtask

  task automatic test_redirect_ack();
    logic got;
    got = 1'b0;
    key = $urandom; lat_min = 1; lat_max = 1; auto_mem = 1'b1;
    reset_dut();
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (fifo_count == 3'd2) got = 1'b1;
    end
    checks++; if (!got || mem_req !== 1'b1) begin errors++; $display("FAIL rack_setup: got count=%0d req=%b expected 2 1", fifo_count, mem_req); end
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rack_flush: got count=%0d valid=%b expected 0 0", fifo_count, inst_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rack_req_drop: got %b expected 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL rack_new_req: got req=%b addr=%h expected 1 100", mem_req, mem_addr); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== (32'h100 ^ key)) begin
      errors++; $display("FAIL rack_first_inst: got valid=%b pc=%h inst=%h expected 1 100 %h", inst_valid, inst_pc, inst, 32'h100 ^ key);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    got = 1'b0;
    auto_mem = 1'b0; man_ack = 1'b0;
    reset_dut();
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL rmid_req: got req=%b expected 1", mem_req); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_rst: got req=%b valid=%b expected 0 0", mem_req, inst_valid); end
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h expected 1 0", mem_req, mem_addr); end
    checks++; if (inst_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_stale_ack: got valid=%b count=%0d expected 0 0", inst_valid, fifo_count); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_wait: got valid=%b expected 0", inst_valid); end
    man_ack = 1'b1; man_rdata = 32'h1234_5678;
    @(negedge clk);
    man_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1234_5678) begin
      errors++; $display("FAIL rmid_first_inst: got valid=%b pc=%h inst=%h expected 1 0 12345678", inst_valid, inst_pc, inst);
    end
    auto_mem = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    logic saw;
    logic wchk;
    int pops;
    saw = 1'b0; wchk = 1'b0; pops = 0;
    key = $urandom; lat_min = 1; lat_max = 1; auto_mem = 1'b1;
    reset_dut();
    inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    exp = 32'hFFFF_FFFC;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      if (mem_req && mem_addr == 32'hFFFF_FFFC) begin
        saw = 1'b1;
      end else if (saw && mem_req && !wchk) begin
        wchk = 1'b1;
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", mem_addr); end
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== exp || inst !== (exp ^ key)) begin
          errors++; $display("FAIL wrap_inst: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp, exp ^ key);
        end
        exp += 32'd4; pops++;
      end
    end
    checks++; if (!wchk || pops < 3) begin errors++; $display("FAIL wrap_progress: got pops=%0d wrapped=%b expected >=3 1", pops, wchk); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int pops;
    exp = 32'h0; pops = 0;
    key = $urandom; lat_min = 1; lat_max = 4; auto_mem = 1'b1;
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      redirect = ($urandom_range(99, 0) < 3);
      redirect_pc = $urandom;
      inst_ready = ($urandom_range(3, 0) != 0);
      if (fifo_count > 3'd4) begin
        checks++; errors++; $display("FAIL rand_overflow: got count=%0d expected <=4", fifo_count);
      end
      if (redirect) begin
        exp = {redirect_pc[31:2], 2'b00};
      end else if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp || inst !== (exp ^ key)) begin
          errors++; $display("FAIL rand_inst: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp, exp ^ key);
        end
        exp += 32'd4; pops++;
      end
    end
    redirect = 1'b0;
    checks++; if (pops < 100) begin errors++; $display("FAIL rand_throughput: got %0d pops expected at least 100", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
